regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Parametrised successor to the CPU's 16x16 register file.
- Multiple asynchronous read ports, two prioritised write-back ports, and optional write-to-read bypass.
- A per-register scoreboard tracks outstanding writes, so the decode stage can detect RAW hazards.
- Sits between decode (read, reserve) and write-back (ALU port 0, load port 1).

Parameters:
DATA_WIDTH, 16, register width in bits
NUM_REGS, 16, number of architectural registers (power of 2, >=2)
ADDR_WIDTH, 4, log2(NUM_REGS)
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = R0 reads 0, ignores writes, never busy; 0 = R0 is an ordinary register
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads return stored value only

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
rd_addr  in  NUM_RD*ADDR_WIDTH  read addresses; port k = bits [k*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  out  NUM_RD*DATA_WIDTH  read data, combinational; port k = bits [k*DATA_WIDTH +: DATA_WIDTH]
rd_busy  out  NUM_RD  1 = register addressed by port k has a pending write
we0  in  1  write enable, port 0 (ALU)
wa0  in  ADDR_WIDTH  write address, port 0
wd0  in  DATA_WIDTH  write data, port 0
we1  in  1  write enable, port 1 (load); wins over port 0
wa1  in  ADDR_WIDTH  write address, port 1
wd1  in  DATA_WIDTH  write data, port 1
rsv_en  in  1  reserve: mark rsv_addr busy (instruction issued)
rsv_addr  in  ADDR_WIDTH  register to reserve
busy_vec  out  NUM_REGS  full scoreboard, bit i = register i busy

Behaviour:
- Reset (async, immediate on rst high): all registers = 0, all busy bits = 0. Hence rd_data = 0, rd_busy = 0, busy_vec = 0 while rst is high.
- Register write, synchronous on posedge clk:
  - weN=1 writes wdN to waN.
  - we0 and we1 both set with wa0==wa1: wd1 is stored, wd0 is discarded.
  - Different addresses: both writes commit in the same cycle.
- ZERO_REG=1: writes to address 0 are dropped; reads of address 0 return 0 and rd_busy 0; busy bit 0 is constant 0 and rsv of 0 is ignored.
- Read path, combinational, zero latency. rd_data[k] is chosen by priority:
  1. 0 if ZERO_REG and addr is 0
  2. wd1 if BYPASS and we1 and wa1==addr
  3. wd0 if BYPASS and we0 and wa0==addr
  4. stored value
- BYPASS=0: a read in the same cycle as a write to that address returns the old value; the new value is visible from the next cycle.
- Scoreboard, per register i, evaluated at posedge:
  - set = rsv_en && rsv_addr==i
  - clr = (we0 && wa0==i) || (we1 && wa1==i)
  - Next state: set -> 1; else clr -> 0; else hold. Reserve wins over a simultaneous clear, so a back-to-back reissue of the same destination stays busy.
  - Reserving an already-busy register keeps it at 1; there is no counter, and decode must stall WAW.
  - A write to a non-busy register is legal: data is stored, busy stays 0.
- rd_busy[k]:
  - Current busy bit of rd_addr[k].
  - If BYPASS=1 and a write to that address occurs this cycle, rd_busy[k]=0, because the data is forwarded.
  - If BYPASS=0, rd_busy[k] reflects the registered bit only.
- busy_vec reflects registered state only; no bypass.
- Reset asserted mid-operation: same-cycle writes and reserves are lost; state is cleared asynchronously. After deassert, the first posedge behaves normally.
- Address widths are exact: no out-of-range addresses exist when NUM_REGS == 2^ADDR_WIDTH.

Test Plan:
- Reset: write 0x1234 to R3, assert rst mid-cycle -> rd_data for R3 = 0x0000 immediately; busy_vec = 0; after release, a read of R3 = 0.
- Basic write/read: we0 wa0=5 wd0=0xBEEF; next cycle rd_addr port0=5 and port1=0 -> rd_data = {0x0000, 0xBEEF}. Write 0x5555 to R0 -> R0 still reads 0.
- Dual-write conflict: we0 wa0=7 wd0=0x1111 and we1 wa1=7 wd1=0x2222 in the same cycle -> R7 = 0x2222. Distinct addresses 2 and 4 -> both stored.
- Bypass: BYPASS=1, read R9 while we1 writes 0xA5A5 to R9 -> same-cycle rd_data = 0xA5A5 and rd_busy=0. Rerun with BYPASS=0 -> old value, new value visible next cycle.
- Scoreboard: rsv R6 -> busy_vec[6]=1 next cycle, rd_busy=1 on R6 read. we0 wa0=6 with rsv_en rsv_addr=6 same cycle -> bit stays 1. Write R6 without rsv -> bit 0.
- Parameter sweep: DATA_WIDTH=32, NUM_REGS=32, NUM_RD=3, ZERO_REG=0 -> R0 writable (0xDEADBEEF reads back); all 3 ports read independent addresses correctly.

Source files
------------

// File: rtl/regfile_sb.sv
// Multi-port register file with prioritised dual write-back, optional
// write-to-read bypass, and a per-register scoreboard for RAW hazard detection.

module regfile_sb_rd_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic [ADDR_WIDTH-1:0]                 addr,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   regs,
  input  logic [NUM_REGS-1:0]                   busy,
  input  logic                                  we0,
  input  logic [ADDR_WIDTH-1:0]                 wa0,
  input  logic [DATA_WIDTH-1:0]                 wd0,
  input  logic                                  we1,
  input  logic [ADDR_WIDTH-1:0]                 wa1,
  input  logic [DATA_WIDTH-1:0]                 wd1,
  output logic [DATA_WIDTH-1:0]                 data,
  output logic                                  rd_busy
);
  logic hit0, hit1, is_zero;

  always_comb begin
    hit0    = (BYPASS != 0) && we0 && (wa0 == addr);
    hit1    = (BYPASS != 0) && we1 && (wa1 == addr);
    is_zero = (ZERO_REG != 0) && (addr == '0);
    data    = regs[addr];
    rd_busy = busy[addr];
    if (hit0) data = wd0;
    if (hit1) data = wd1;
    // forwarded data satisfies the hazard, so the reader need not stall
    if (hit0 || hit1) rd_busy = 1'b0;
    if (is_zero) begin
      data    = '0;
      rd_busy = 1'b0;
    end
  end
endmodule

module regfile_sb #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic                           we0,
  input  logic [ADDR_WIDTH-1:0]          wa0,
  input  logic [DATA_WIDTH-1:0]          wd0,
  input  logic                           we1,
  input  logic [ADDR_WIDTH-1:0]          wa1,
  input  logic [DATA_WIDTH-1:0]          wd1,
  input  logic                           rsv_en,
  input  logic [ADDR_WIDTH-1:0]          rsv_addr,
  output logic [NUM_REGS-1:0]            busy_vec
);
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]                 busy_q, busy_d;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]   lane_data;
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]   lane_addr;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (we0 && wa0 == ADDR_WIDTH'(i)) regs_d[i] = wd0;
      if (we1 && wa1 == ADDR_WIDTH'(i)) regs_d[i] = wd1;
      if ((we0 && wa0 == ADDR_WIDTH'(i)) || (we1 && wa1 == ADDR_WIDTH'(i)))
        busy_d[i] = 1'b0;
      // reserve after clear: a back-to-back reissue keeps the register busy
      if (rsv_en && rsv_addr == ADDR_WIDTH'(i)) busy_d[i] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign lane_addr = rd_addr;
  assign rd_data   = lane_data;
  assign busy_vec  = busy_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_sb_rd_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
    ) u_lane (
      .addr    (lane_addr[k]),
      .regs    (regs_q),
      .busy    (busy_q),
      .we0     (we0),
      .wa0     (wa0),
      .wd0     (wd0),
      .we1     (we1),
      .wa1     (wa1),
      .wd1     (wd1),
      .data    (lane_data[k]),
      .rd_busy (rd_busy[k])
    );
  end
endmodule
